// File: rtl/fibo_stream_checker.sv
// Checks a Fibonacci sample stream: seeds from two samples, then predicts each sample as the mod-2^W sum of the previous two.
// Pulses, lock and error count are registered, so they appear 1 cycle after the sample; expected is combinational from state; no backpressure.
module fibo_stream_checker #(
    parameter int W      = 8,
    parameter int LOCK_N = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic [W-1:0]     expected,
    output logic             match_pulse,
    output logic             err_pulse,
    output logic             locked,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {SEED0, SEED1, TRACK} state_t;

    localparam logic [3:0] LOCK_V = 4'(LOCK_N);

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   prev_a;
    logic [W-1:0]   prev_b;
    logic [W-1:0]   sum;
    logic [3:0]     run;
    logic [3:0]     run_inc;
    logic           hit;
    logic           miss;

    // Carry out of the sum is discarded on purpose: the stream wraps mod 2^W.
    assign sum     = W'(prev_a + prev_b);
    assign hit     = in_valid && (state == TRACK) && (in_data == sum);
    assign miss    = in_valid && (state == TRACK) && (in_data != sum);
    assign run_inc = (run >= LOCK_V) ? LOCK_V : run + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= SEED0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEED0:   if (in_valid) state_nxt = SEED1;
            SEED1:   if (in_valid) state_nxt = TRACK;
            TRACK:   if (miss)     state_nxt = SEED1;
            default: state_nxt = SEED0;
        endcase
    end

    always_comb begin
        expected = '0;
        if (state == TRACK) begin
            expected = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_a      <= '0;
            prev_b      <= '0;
            run         <= '0;
            match_pulse <= 1'b0;
            err_pulse   <= 1'b0;
            locked      <= 1'b0;
            err_count   <= '0;
        end else begin
            match_pulse <= hit;
            err_pulse   <= miss;
            if (in_valid) begin
                case (state)
                    SEED0: prev_a <= in_data;
                    SEED1: prev_b <= in_data;
                    TRACK: begin
                        if (hit) begin
                            prev_a <= prev_b;
                            prev_b <= in_data;
                            run    <= run_inc;
                            locked <= (run_inc == LOCK_V);
                        end else begin
                            // Resync: the bad sample becomes the first seed.
                            prev_a <= in_data;
                            run    <= '0;
                            locked <= 1'b0;
                            if (err_count != {CNT_W{1'b1}}) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                        end
                    end
                    default: prev_a <= prev_a;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fibo_stream_checker.sv
// Directed bench for fibo_stream_checker: main instance with defaults, second instance with CNT_W=4, LOCK_N=1.
module tb_fibo_stream_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [7:0]  expected;
    logic        match_pulse;
    logic        err_pulse;
    logic        locked;
    logic [15:0] err_count;

    logic        s_valid;
    logic [7:0]  s_data;
    logic [7:0]  s_expected;
    logic        s_match;
    logic        s_err;
    logic        s_locked;
    logic [3:0]  s_err_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fibo_stream_checker dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .expected    (expected),
        .match_pulse (match_pulse),
        .err_pulse   (err_pulse),
        .locked      (locked),
        .err_count   (err_count)
    );

    fibo_stream_checker #(.W(8), .LOCK_N(1), .CNT_W(4)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (s_valid),
        .in_data     (s_data),
        .expected    (s_expected),
        .match_pulse (s_match),
        .err_pulse   (s_err),
        .locked      (s_locked),
        .err_count   (s_err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic m, input logic e, input logic lk,
                             input logic [7:0] ex, input logic [15:0] ec);
        check({tag, ".match"},    match_pulse, m);
        check({tag, ".err"},      err_pulse,   e);
        check({tag, ".locked"},   locked,      lk);
        check({tag, ".expected"}, expected,    ex);
        check({tag, ".err_count"}, err_count,  ec);
    endtask

    task automatic row(input string tag, input logic [7:0] d, input logic m, input logic e,
                       input logic lk, input logic [7:0] ex, input logic [15:0] ec);
        step(1'b1, d);
        check_all(tag, m, e, lk, ex, ec);
    endtask

    task automatic stall(input string tag, input logic lk, input logic [7:0] ex, input logic [15:0] ec);
        step(1'b0, 8'($urandom));
        check_all(tag, 1'b0, 1'b0, lk, ex, ec);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        step(1'b1, 8'd77);
        rst = 1'b1;
        check_all(tag, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    endtask

    initial begin
        int nerr;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        s_valid  = 1'b0;
        s_data   = 8'd0;
        step(1'b1, 8'h55);
        do_reset("rst0");
        check("rst0.s_err_count", s_err_count, 4'd0);
        check("rst0.s_locked",    s_locked,    1'b0);

        // Clean stream, then continue across the 8-bit wrap.
        row("c0",   8'd0,   0, 0, 0, 8'd0,   16'd0);
        row("c1",   8'd1,   0, 0, 0, 8'd1,   16'd0);
        row("c2",   8'd1,   1, 0, 0, 8'd2,   16'd0);
        row("c3",   8'd2,   1, 0, 0, 8'd3,   16'd0);
        row("c4",   8'd3,   1, 0, 0, 8'd5,   16'd0);
        row("c5",   8'd5,   1, 0, 1, 8'd8,   16'd0);
        row("c6",   8'd8,   1, 0, 1, 8'd13,  16'd0);
        row("c7",   8'd13,  1, 0, 1, 8'd21,  16'd0);
        row("w0",   8'd21,  1, 0, 1, 8'd34,  16'd0);
        row("w1",   8'd34,  1, 0, 1, 8'd55,  16'd0);
        row("w2",   8'd55,  1, 0, 1, 8'd89,  16'd0);
        row("w3",   8'd89,  1, 0, 1, 8'd144, 16'd0);
        row("w4",   8'd144, 1, 0, 1, 8'd233, 16'd0);
        row("w5",   8'd233, 1, 0, 1, 8'd121, 16'd0);
        row("w6",   8'd121, 1, 0, 1, 8'd98,  16'd0);
        row("w7",   8'd98,  1, 0, 1, 8'd219, 16'd0);
        row("w8",   8'd219, 1, 0, 1, 8'd61,  16'd0);

        // Same clean stream with stall cycles interleaved.
        do_reset("rst1");
        row("s0",   8'd0,   0, 0, 0, 8'd0,   16'd0);
        row("s1",   8'd1,   0, 0, 0, 8'd1,   16'd0);
        stall("st1", 0, 8'd1, 16'd0);
        row("s2",   8'd1,   1, 0, 0, 8'd2,   16'd0);
        row("s3",   8'd2,   1, 0, 0, 8'd3,   16'd0);
        stall("st2", 0, 8'd3, 16'd0);
        row("s4",   8'd3,   1, 0, 0, 8'd5,   16'd0);
        row("s5",   8'd5,   1, 0, 1, 8'd8,   16'd0);
        row("s6",   8'd8,   1, 0, 1, 8'd13,  16'd0);
        stall("st3", 1, 8'd13, 16'd0);
        row("s7",   8'd13,  1, 0, 1, 8'd21,  16'd0);

        // Single corruption, resync, then relock after four more matches.
        do_reset("rst2");
        row("k0",   8'd0,   0, 0, 0, 8'd0,   16'd0);
        row("k1",   8'd1,   0, 0, 0, 8'd1,   16'd0);
        row("k2",   8'd1,   1, 0, 0, 8'd2,   16'd0);
        row("k3",   8'd2,   1, 0, 0, 8'd3,   16'd0);
        row("k4",   8'd3,   1, 0, 0, 8'd5,   16'd0);
        row("k5",   8'd5,   1, 0, 1, 8'd8,   16'd0);
        row("k6",   8'd9,   0, 1, 0, 8'd0,   16'd1);
        row("k7",   8'd13,  0, 0, 0, 8'd22,  16'd1);
        row("k8",   8'd22,  1, 0, 0, 8'd35,  16'd1);
        row("k9",   8'd35,  1, 0, 0, 8'd57,  16'd1);
        row("k10",  8'd57,  1, 0, 0, 8'd92,  16'd1);
        row("k11",  8'd92,  1, 0, 1, 8'd149, 16'd1);

        // Reset with a simultaneous valid sample while locked, then reseed.
        do_reset("rst3");
        row("r0",   8'd8,   0, 0, 0, 8'd0,   16'd0);
        row("r1",   8'd13,  0, 0, 0, 8'd21,  16'd0);
        row("r2",   8'd21,  1, 0, 0, 8'd34,  16'd0);
        in_valid = 1'b0;

        // Constant-1 stream on the 4-bit counter instance: every other sample mispredicts.
        nerr = 0;
        s_valid = 1'b1;
        s_data  = 8'd1;
        for (int i = 0; i < 41; i++) begin
            @(posedge clk);
            #1;
            if (s_err) nerr++;
            if (i == 30) check("sat.cnt15", s_err_count, 4'd15);
            if (i == 32) check("sat.nowrap", s_err_count, 4'd15);
        end
        check("sat.pulses", nerr, 20);
        check("sat.final", s_err_count, 4'd15);
        check("sat.locked", s_locked, 1'b0);
        @(posedge clk);
        #1;
        s_data = 8'd2;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        check("lock1.match",    s_match,     1'b1);
        check("lock1.locked",   s_locked,    1'b1);
        check("lock1.expected", s_expected,  8'd3);
        check("lock1.cnt",      s_err_count, 4'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
